memoria_dados_parametrizada: RTL and testbench

Parametrised, byte-addressed, little-endian data memory for the MIPS-PCS datapath. It replaces the fixed 16-bit single-cycle data memory.
- Adds configurable word width and depth.
- Adds byte, halfword and word access sizes, with sign or zero extension on narrow loads.
- Adds a request/response handshake with a configurable number of wait states.
- Reports misalignment and out-of-range errors.
It sits between the MEM stage control (or a stall-capable controller) and storage.

---
 rtl/memoria_dados_parametrizada.sv | 199 +++++++++++++++++++
 tb/tb_memoria_dados_parametrizada.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/memoria_dados_parametrizada.sv
// Byte-addressed little-endian data memory with a request/response handshake.
// One access is in flight at a time. The legality check, the store commit and
// the load capture all happen on the single edge that enters RESPOSTA.
module memoria_dados_parametrizada #(
  parameter int LARGURA_DADOS      = 16,
  parameter int LARGURA_ENDERECO   = 16,
  parameter int PROFUNDIDADE_BYTES = 256,
  parameter int LATENCIA           = 1
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        req_valido,
  output logic                        req_pronto,
  input  logic                        escrita,
  input  logic [1:0]                  tamanho,
  input  logic                        sinal_estendido,
  input  logic [LARGURA_ENDERECO-1:0] endereco,
  input  logic [LARGURA_DADOS-1:0]    dado_escrita,
  output logic                        resp_valido,
  output logic [LARGURA_DADOS-1:0]    dado_leitura,
  output logic                        erro_alinhamento,
  output logic                        erro_faixa
);

  localparam int BP = LARGURA_DADOS / 8;
  localparam int LI = (PROFUNDIDADE_BYTES > 1) ? $clog2(PROFUNDIDADE_BYTES) : 1;
  localparam int LC = (LATENCIA > 1) ? $clog2(LATENCIA) : 1;
  // One extra bit so that endereco + N never wraps around.
  localparam int LS = LARGURA_ENDERECO + 1;

  typedef enum logic [1:0] {OCIOSO, ESPERA, RESPOSTA} estado_t;

  estado_t                     estado_q, estado_d;
  logic [LC-1:0]               contador_q, contador_d;
  logic                        escrita_q, sinal_q;
  logic [1:0]                  tamanho_q;
  logic [LARGURA_ENDERECO-1:0] endereco_q;
  logic [LARGURA_DADOS-1:0]    dado_q;
  logic                        resp_valido_q, resp_valido_d;
  logic [LARGURA_DADOS-1:0]    dado_leitura_q, dado_leitura_d;
  logic                        erro_al_q, erro_al_d, erro_fx_q, erro_fx_d;

  logic [7:0] mem_q [PROFUNDIDADE_BYTES];

  // Effective request: live inputs while idle (so LATENCIA = 1 can respond on
  // the accepting edge), latched copy while waiting.
  logic                        ocioso;
  logic                        ef_escrita, ef_sinal;
  logic [1:0]                  ef_tamanho;
  logic [LARGURA_ENDERECO-1:0] ef_end;
  logic [LARGURA_DADOS-1:0]    ef_dado;

  assign ocioso     = (estado_q == OCIOSO);
  assign ef_escrita = ocioso ? escrita         : escrita_q;
  assign ef_sinal   = ocioso ? sinal_estendido : sinal_q;
  assign ef_tamanho = ocioso ? tamanho         : tamanho_q;
  assign ef_end     = ocioso ? endereco        : endereco_q;
  assign ef_dado    = ocioso ? dado_escrita    : dado_q;

  // Per-lane byte addresses and raw little-endian word assembled from storage.
  logic [LS-1:0]            end_lane [BP];
  logic [LARGURA_DADOS-1:0] bruto;

  genvar gi;
  generate
    for (gi = 0; gi < BP; gi++) begin : g_lane
      assign end_lane[gi] = {1'b0, ef_end} + LS'(gi);
      assign bruto[gi*8 +: 8] = (end_lane[gi] < LS'(PROFUNDIDADE_BYTES))
                                ? mem_q[end_lane[gi][LI-1:0]] : 8'h00;
    end
  endgenerate

  logic [LS-1:0]            n_bytes;
  logic                     desalinhado, fora_faixa, estende, bit_topo;
  int                       limite_bits;
  logic [LARGURA_DADOS-1:0] dado_ext;

  // Access size, legality checks and load extension.
  always_comb begin
    n_bytes     = LS'(1);
    desalinhado = 1'b0;
    limite_bits = 8;
    bit_topo    = bruto[7];
    case (ef_tamanho)
      2'b00: ;
      2'b01: begin
        n_bytes     = LS'(2);
        desalinhado = ef_end[0];
        limite_bits = 16;
        bit_topo    = bruto[15];
      end
      2'b10: begin
        n_bytes     = LS'(BP);
        desalinhado = ((LS'(ef_end) % LS'(BP)) != '0);
        limite_bits = LARGURA_DADOS;
        bit_topo    = bruto[LARGURA_DADOS-1];
      end
      default: desalinhado = 1'b1;
    endcase
    fora_faixa = (({1'b0, ef_end} + n_bytes) > LS'(PROFUNDIDADE_BYTES));
    estende    = ef_sinal && (ef_tamanho != 2'b10);
    for (int i = 0; i < LARGURA_DADOS; i++) begin
      dado_ext[i] = (i < limite_bits) ? bruto[i] : (estende & bit_topo);
    end
  end

  logic entra_resposta, grava_mem;

  // Next-state and response logic.
  always_comb begin
    estado_d       = estado_q;
    contador_d     = contador_q;
    resp_valido_d  = 1'b0;
    dado_leitura_d = dado_leitura_q;
    erro_al_d      = erro_al_q;
    erro_fx_d      = erro_fx_q;
    entra_resposta = 1'b0;
    case (estado_q)
      OCIOSO: begin
        if (req_valido) begin
          if (LATENCIA == 1) begin
            entra_resposta = 1'b1;
          end else begin
            estado_d   = ESPERA;
            contador_d = LC'(LATENCIA - 1);
          end
        end
      end
      ESPERA: begin
        if (contador_q <= LC'(1)) entra_resposta = 1'b1;
        else                      contador_d     = contador_q - LC'(1);
      end
      default: estado_d = OCIOSO;
    endcase
    if (entra_resposta) begin
      estado_d       = RESPOSTA;
      contador_d     = '0;
      resp_valido_d  = 1'b1;
      erro_al_d      = desalinhado;
      erro_fx_d      = fora_faixa;
      dado_leitura_d = (desalinhado || fora_faixa || ef_escrita) ? '0 : dado_ext;
    end
  end

  // A store commits only if legal and not while reset is held.
  assign grava_mem = entra_resposta && ef_escrita && !desalinhado && !fora_faixa && reset_n;

  // FSM, counter and registered response outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado_q       <= OCIOSO;
      contador_q     <= '0;
      resp_valido_q  <= 1'b0;
      dado_leitura_q <= '0;
      erro_al_q      <= 1'b0;
      erro_fx_q      <= 1'b0;
    end else begin
      estado_q       <= estado_d;
      contador_q     <= contador_d;
      resp_valido_q  <= resp_valido_d;
      dado_leitura_q <= dado_leitura_d;
      erro_al_q      <= erro_al_d;
      erro_fx_q      <= erro_fx_d;
    end
  end

  // Request capture on acceptance.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      escrita_q  <= 1'b0;
      sinal_q    <= 1'b0;
      tamanho_q  <= 2'b00;
      endereco_q <= '0;
      dado_q     <= '0;
    end else if (ocioso && req_valido) begin
      escrita_q  <= escrita;
      sinal_q    <= sinal_estendido;
      tamanho_q  <= tamanho;
      endereco_q <= endereco;
      dado_q     <= dado_escrita;
    end
  end

  // Byte storage; contents survive reset, only the N addressed bytes change.
  always_ff @(posedge clock) begin
    if (grava_mem) begin
      for (int k = 0; k < BP; k++) begin
        if (LS'(k) < n_bytes) mem_q[end_lane[k][LI-1:0]] <= ef_dado[8*k +: 8];
      end
    end
  end

  assign req_pronto       = ocioso;
  assign resp_valido      = resp_valido_q;
  assign dado_leitura     = dado_leitura_q;
  assign erro_alinhamento = erro_al_q;
  assign erro_faixa       = erro_fx_q;

endmodule

// File: tb/tb_memoria_dados_parametrizada.sv
// Bench for two instances: 16-bit word with one cycle of latency, and
// 32-bit word with three cycles of latency. Expected responses are queued
// when a request is issued and popped when the instance answers.
module tb_memoria_dados_parametrizada;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic [1:0]  req_valido = 2'b00;
  logic        escrita = 1'b0;
  logic [1:0]  tamanho = 2'b00;
  logic        sinal_estendido = 1'b0;
  logic [15:0] endereco = 16'h0;
  logic [31:0] dado_escrita = 32'h0;

  logic        pronto16, resp16, eal16, efx16;
  logic [15:0] dado16;
  logic        pronto32, resp32, eal32, efx32;
  logic [31:0] dado32;

  int testes = 0;
  int falhas = 0;

  typedef struct {
    logic [31:0] dado;
    logic        eal;
    logic        efx;
  } esp_t;

  esp_t  fila0[$], fila1[$];
  string tag0[$], tag1[$];

  always #5 clock = ~clock;

  memoria_dados_parametrizada #(
    .LARGURA_DADOS(16), .LARGURA_ENDERECO(16), .PROFUNDIDADE_BYTES(256), .LATENCIA(1)
  ) u_mem16 (
    .clock(clock), .reset_n(reset_n), .req_valido(req_valido[0]), .req_pronto(pronto16),
    .escrita(escrita), .tamanho(tamanho), .sinal_estendido(sinal_estendido),
    .endereco(endereco), .dado_escrita(dado_escrita[15:0]), .resp_valido(resp16),
    .dado_leitura(dado16), .erro_alinhamento(eal16), .erro_faixa(efx16)
  );

  memoria_dados_parametrizada #(
    .LARGURA_DADOS(32), .LARGURA_ENDERECO(16), .PROFUNDIDADE_BYTES(256), .LATENCIA(3)
  ) u_mem32 (
    .clock(clock), .reset_n(reset_n), .req_valido(req_valido[1]), .req_pronto(pronto32),
    .escrita(escrita), .tamanho(tamanho), .sinal_estendido(sinal_estendido),
    .endereco(endereco), .dado_escrita(dado_escrita), .resp_valido(resp32),
    .dado_leitura(dado32), .erro_alinhamento(eal32), .erro_faixa(efx32)
  );

  task automatic confere(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    testes++;
    if (obs !== esp) begin
      falhas++;
      $display("FAIL %s: got %h expected %h", tag, obs, esp);
    end
  endtask

  // Response scoreboards, sampled on the falling edge.
  always @(negedge clock) begin : mon16
    esp_t  e;
    string t;
    if (resp16) begin
      if (fila0.size() == 0) begin
        confere("mem16.resp_inesperada", 32'd1, 32'd0);
      end else begin
        e = fila0.pop_front();
        t = tag0.pop_front();
        confere({t, ".dado"}, {16'h0, dado16}, e.dado);
        confere({t, ".eal"}, {31'h0, eal16}, {31'h0, e.eal});
        confere({t, ".efx"}, {31'h0, efx16}, {31'h0, e.efx});
        $display("[TB] mem16 %s dado=%h eal=%b efx=%b", t, dado16, eal16, efx16);
      end
    end
  end

  always @(negedge clock) begin : mon32
    esp_t  e;
    string t;
    if (resp32) begin
      if (fila1.size() == 0) begin
        confere("mem32.resp_inesperada", 32'd1, 32'd0);
      end else begin
        e = fila1.pop_front();
        t = tag1.pop_front();
        confere({t, ".dado"}, dado32, e.dado);
        confere({t, ".eal"}, {31'h0, eal32}, {31'h0, e.eal});
        confere({t, ".efx"}, {31'h0, efx32}, {31'h0, e.efx});
        $display("[TB] mem32 %s dado=%h eal=%b efx=%b", t, dado32, eal32, efx32);
      end
    end
  end

  task automatic empilha(input int sel, input string tag, input logic [31:0] d,
                         input logic eal, input logic efx);
    esp_t e;
    e.dado = d; e.eal = eal; e.efx = efx;
    if (sel == 0) begin fila0.push_back(e); tag0.push_back(tag); end
    else          begin fila1.push_back(e); tag1.push_back(tag); end
  endtask

  function automatic logic pronto_de(input int sel);
    return (sel == 0) ? pronto16 : pronto32;
  endfunction

  function automatic logic resp_de(input int sel);
    return (sel == 0) ? resp16 : resp32;
  endfunction

  // One complete access; entered and left on a falling edge.
  task automatic acesso(input int sel, input string tag, input logic w, input logic [1:0] t,
                        input logic s, input logic [15:0] a, input logic [31:0] d,
                        input logic [31:0] esp, input logic eal, input logic efx);
    int n;
    int lat;
    lat = (sel == 0) ? 1 : 3;
    empilha(sel, tag, esp, eal, efx);
    escrita = w; tamanho = t; sinal_estendido = s; endereco = a; dado_escrita = d;
    req_valido[sel] = 1'b1;
    n = 0;
    while (!pronto_de(sel) && n < 20) begin @(negedge clock); n++; end
    confere({tag, ".pronto"}, {31'h0, pronto_de(sel)}, 32'd1);
    @(posedge clock);
    n = 0;
    do begin
      @(negedge clock);
      n++;
      if (n == 1) begin
        req_valido[sel] = 1'b0;
        escrita = 1'($urandom); tamanho = 2'($urandom);
        endereco = 16'($urandom); dado_escrita = $urandom;
      end
    end while (!resp_de(sel) && n < 20);
    confere({tag, ".latencia"}, 32'(n), 32'(lat));
    @(negedge clock);
    confere({tag, ".pulso"}, {31'h0, resp_de(sel)}, 32'd0);
    confere({tag, ".hold"}, (sel == 0) ? {16'h0, dado16} : dado32, esp);
  endtask

  typedef struct {
    logic [1:0]  t;
    logic        s;
    logic [15:0] a;
    logic [31:0] esp;
  } carga_t;

  initial begin : principal
    carga_t cargas [3];
    #1 reset_n = 1'b0;
    @(negedge clock);
    confere("reset.pronto16", {31'h0, pronto16}, 32'd1);
    confere("reset.pronto32", {31'h0, pronto32}, 32'd1);
    confere("reset.resp", {30'h0, resp32, resp16}, 32'd0);
    confere("reset.dado", dado32 | {16'h0, dado16}, 32'd0);
    confere("reset.erros", {28'h0, eal16, efx16, eal32, efx32}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    // 16-bit, one cycle of latency
    acesso(0, "st_h_beef",   1, 2'b01, 0, 16'h0010, 32'h0000BEEF, 32'h0000, 0, 0);
    acesso(0, "ld_h_10",     0, 2'b01, 0, 16'h0010, 32'h0,        32'hBEEF, 0, 0);
    acesso(0, "ld_b_10_z",   0, 2'b00, 0, 16'h0010, 32'h0,        32'h00EF, 0, 0);
    acesso(0, "ld_b_11_s",   0, 2'b00, 1, 16'h0011, 32'h0,        32'hFFBE, 0, 0);
    acesso(0, "ld_b_11_z",   0, 2'b00, 0, 16'h0011, 32'h0,        32'h00BE, 0, 0);
    acesso(0, "ld_w16_10",   0, 2'b10, 1, 16'h0010, 32'h0,        32'hBEEF, 0, 0);
    acesso(0, "st_h_02",     1, 2'b01, 0, 16'h0002, 32'h7777,     32'h0000, 0, 0);
    acesso(0, "st_h_03_al",  1, 2'b01, 0, 16'h0003, 32'h1234,     32'h0000, 1, 0);
    acesso(0, "ld_h_02",     0, 2'b01, 0, 16'h0002, 32'h0,        32'h7777, 0, 0);
    acesso(0, "ld_h_04",     0, 2'b01, 0, 16'h0004, 32'h0,        32'h0000, 0, 0);
    acesso(0, "ld_h_02_al",  0, 2'b01, 0, 16'h0003, 32'h0,        32'h0000, 1, 0);
    acesso(0, "st_h_ff",     1, 2'b01, 0, 16'h00FF, 32'hABCD,     32'h0000, 1, 1);
    acesso(0, "ld_h_100",    0, 2'b01, 0, 16'h0100, 32'h0,        32'h0000, 0, 1);
    acesso(0, "st_b_ff",     1, 2'b00, 0, 16'h00FF, 32'h9980,     32'h0000, 0, 0);
    acesso(0, "ld_b_ff_s",   0, 2'b00, 1, 16'h00FF, 32'h0,        32'hFF80, 0, 0);
    acesso(0, "ld_b_fe",     0, 2'b00, 0, 16'h00FE, 32'h0,        32'h0000, 0, 0);
    acesso(0, "ld_t11",      0, 2'b11, 0, 16'h0010, 32'h0,        32'h0000, 1, 0);
    acesso(0, "ld_b_ffff",   0, 2'b00, 0, 16'hFFFF, 32'h0,        32'h0000, 0, 1);

    // 32-bit, three cycles of latency
    acesso(1, "st_w_20",     1, 2'b10, 0, 16'h0020, 32'h11223344, 32'h0, 0, 0);
    acesso(1, "st_b_21",     1, 2'b00, 0, 16'h0021, 32'hFFFFFFAA, 32'h0, 0, 0);
    acesso(1, "ld_w_20",     0, 2'b10, 1, 16'h0020, 32'h0, 32'h1122AA44, 0, 0);
    acesso(1, "ld_b_21_z",   0, 2'b00, 0, 16'h0021, 32'h0, 32'h000000AA, 0, 0);
    acesso(1, "ld_b_21_s",   0, 2'b00, 1, 16'h0021, 32'h0, 32'hFFFFFFAA, 0, 0);
    acesso(1, "ld_h_20_s",   0, 2'b01, 1, 16'h0020, 32'h0, 32'hFFFFAA44, 0, 0);
    acesso(1, "ld_h_22_s",   0, 2'b01, 1, 16'h0022, 32'h0, 32'h00001122, 0, 0);
    acesso(1, "ld_w_22_al",  0, 2'b10, 0, 16'h0022, 32'h0, 32'h0,        1, 0);
    acesso(1, "st_w_22_al",  1, 2'b10, 0, 16'h0022, 32'hDEADBEEF, 32'h0, 1, 0);
    acesso(1, "ld_w_20_b",   0, 2'b10, 0, 16'h0020, 32'h0, 32'h1122AA44, 0, 0);
    acesso(1, "ld_w_24",     0, 2'b10, 0, 16'h0024, 32'h0, 32'h00000000, 0, 0);
    acesso(1, "st_w_30",     1, 2'b10, 0, 16'h0030, 32'hFFFFFFFF, 32'h0, 0, 0);
    acesso(1, "st_h_30",     1, 2'b01, 0, 16'h0030, 32'h55551234, 32'h0, 0, 0);
    acesso(1, "ld_w_30",     0, 2'b10, 0, 16'h0030, 32'h0, 32'hFFFF1234, 0, 0);
    acesso(1, "ld_w_fc",     0, 2'b10, 0, 16'h00FC, 32'h0, 32'h00000000, 0, 0);
    acesso(1, "ld_w_100",    0, 2'b10, 0, 16'h0100, 32'h0, 32'h00000000, 0, 1);

    // Back-to-back with req_valido held: accept every 4 cycles, junk while waiting.
    cargas[0] = '{2'b10, 1'b0, 16'h0020, 32'h1122AA44};
    cargas[1] = '{2'b10, 1'b0, 16'h0030, 32'hFFFF1234};
    cargas[2] = '{2'b00, 1'b1, 16'h0021, 32'hFFFFFFAA};
    empilha(1, "b2b_0", cargas[0].esp, 0, 0);
    empilha(1, "b2b_1", cargas[1].esp, 0, 0);
    empilha(1, "b2b_2", cargas[2].esp, 0, 0);
    req_valido[1] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      confere($sformatf("b2b.pronto_%0d", i), {31'h0, pronto32}, (i % 4 == 0) ? 32'd1 : 32'd0);
      if (i % 4 == 0) begin
        escrita = 1'b0; tamanho = cargas[i/4].t; sinal_estendido = cargas[i/4].s;
        endereco = cargas[i/4].a; dado_escrita = 32'h0;
      end else begin
        escrita = 1'($urandom); tamanho = 2'($urandom); sinal_estendido = 1'($urandom);
        endereco = 16'($urandom); dado_escrita = $urandom;
      end
      @(negedge clock);
    end
    req_valido[1] = 1'b0;
    escrita = 1'b0;
    @(negedge clock);
    confere("b2b.fila", 32'(fila1.size()), 32'd0);

    // Reset during ESPERA discards a pending store.
    acesso(1, "st_h_40",     1, 2'b01, 0, 16'h0040, 32'h00005555, 32'h0, 0, 0);
    acesso(1, "ld_h_40",     0, 2'b01, 0, 16'h0040, 32'h0, 32'h00005555, 0, 0);
    escrita = 1'b1; tamanho = 2'b01; sinal_estendido = 1'b0;
    endereco = 16'h0040; dado_escrita = 32'h00001234;
    req_valido[1] = 1'b1;
    @(posedge clock);
    @(negedge clock);
    req_valido[1] = 1'b0;
    confere("rst_meio.espera", {31'h0, pronto32}, 32'd0);
    reset_n = 1'b0;
    #1;
    confere("rst_meio.pronto", {31'h0, pronto32}, 32'd1);
    confere("rst_meio.resp", {31'h0, resp32}, 32'd0);
    confere("rst_meio.dado", dado32, 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    escrita = 1'b0;
    repeat (4) @(negedge clock);
    acesso(1, "ld_h_40_pos", 0, 2'b01, 0, 16'h0040, 32'h0, 32'h00005555, 0, 0);

    confere("fila16.vazia", 32'(fila0.size()), 32'd0);
    confere("fila32.vazia", 32'(fila1.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testes, falhas);
    $finish;
  end

  initial begin : limite_tempo
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
